// File: rtl/elevator_motion_controller_if.sv
// Signal bundle between the dispatch/scoring stage and the two-car motion
// controller. The estop line exists only when ELEVATOR_ESTOP_EN is defined.
interface elevator_motion_controller_if;
  logic [1:0]  simState;
  logic [1:0]  directions;
  logic [11:0] FloorDestinations;
  logic [7:0]  half_elevatorPositions;
  logic [11:0] floorArrived;
  logic [1:0]  doorsOpen;
  logic [1:0]  moving;
`ifdef ELEVATOR_ESTOP_EN
  logic        estop;

  modport master (
    output simState, directions, FloorDestinations, estop,
    input  half_elevatorPositions, floorArrived, doorsOpen, moving
  );
  modport slave (
    input  simState, directions, FloorDestinations, estop,
    output half_elevatorPositions, floorArrived, doorsOpen, moving
  );
`else
  modport master (
    output simState, directions, FloorDestinations,
    input  half_elevatorPositions, floorArrived, doorsOpen, moving
  );
  modport slave (
    input  simState, directions, FloorDestinations,
    output half_elevatorPositions, floorArrived, doorsOpen, moving
  );
`endif
endinterface

// File: rtl/elevator_motion_controller.sv
// Two independent elevator cars (left = 0, right = 1), each an IDLE/MOVE/DOOR
// FSM stepping in half-floor increments 0..10 (even index = at a floor).
// Optional feature: define ELEVATOR_ESTOP_EN to add bus.estop, which freezes
// both cars and forces doors open for cars standing at a floor.
module elevator_motion_controller #(
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned DOOR_CYCLES = 3000
) (
  input  logic                        clk,
  input  logic                        rst,
  elevator_motion_controller_if.slave bus
);

  localparam int unsigned SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t        state    [2];
  logic [3:0]    pos      [2];
  logic [SW-1:0] step_cnt [2];
  logic [DW-1:0] door_cnt [2];
  logic          dir      [2];
  logic [5:0]    arrived  [2];
  logic [1:0]    door_q;
  logic [1:0]    move_q;

  logic [5:0]    dest     [2];
  logic [3:0]    step_pos [2];
  logic          run;

  function automatic logic blocked(input logic up, input logic [3:0] p);
    return up ? (p == 4'd10) : (p == 4'd0);
  endfunction

  assign dest[0] = bus.FloorDestinations[5:0];
  assign dest[1] = bus.FloorDestinations[11:6];

`ifdef ELEVATOR_ESTOP_EN
  assign run = (bus.simState == 2'b01) && !bus.estop;
`else
  assign run = (bus.simState == 2'b01);
`endif

  // Half-floor index each car lands on when its current step completes.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      step_pos[i] = dir[i] ? (pos[i] + 4'd1) : (pos[i] - 4'd1);
    end
  end

  // Per-car motion FSM with counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i]    <= IDLE;
        pos[i]      <= '0;
        step_cnt[i] <= '0;
        door_cnt[i] <= '0;
        dir[i]      <= 1'b0;
        arrived[i]  <= '0;
      end
      door_q <= '0;
      move_q <= '0;
    end else if (!run) begin
      for (int unsigned i = 0; i < 2; i++) begin
        arrived[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        arrived[i] <= '0;
        unique case (state[i])
          IDLE: begin
            if (!pos[i][0] && dest[i][pos[i][3:1]]) begin
              state[i]                   <= DOOR;
              door_cnt[i]                <= '0;
              arrived[i][pos[i][3:1]]    <= 1'b1;
              door_q[i]                  <= 1'b1;
            end else if ((dest[i] != '0) && !blocked(bus.directions[i], pos[i])) begin
              state[i]    <= MOVE;
              dir[i]      <= bus.directions[i];
              step_cnt[i] <= '0;
              move_q[i]   <= 1'b1;
            end
          end
          MOVE: begin
            if (step_cnt[i] == STEP_LAST) begin
              step_cnt[i] <= '0;
              pos[i]      <= step_pos[i];
              // Odd landing: keep moving with the latched direction; decisions
              // are only taken once the car reaches a floor.
              if (!step_pos[i][0]) begin
                if (dest[i][step_pos[i][3:1]]) begin
                  state[i]                     <= DOOR;
                  door_cnt[i]                  <= '0;
                  arrived[i][step_pos[i][3:1]] <= 1'b1;
                  door_q[i]                    <= 1'b1;
                  move_q[i]                    <= 1'b0;
                end else if (dest[i] == '0) begin
                  state[i]  <= IDLE;
                  move_q[i] <= 1'b0;
                end else begin
                  dir[i] <= bus.directions[i];
                  if (blocked(bus.directions[i], step_pos[i])) begin
                    state[i]  <= IDLE;
                    move_q[i] <= 1'b0;
                  end
                end
              end
            end else begin
              step_cnt[i] <= step_cnt[i] + SW'(1);
            end
          end
          DOOR: begin
            if (door_cnt[i] == DOOR_LAST) begin
              state[i]    <= IDLE;
              door_cnt[i] <= '0;
              door_q[i]   <= 1'b0;
            end else begin
              door_cnt[i] <= door_cnt[i] + DW'(1);
            end
          end
          default: begin
            state[i]  <= IDLE;
            door_q[i] <= 1'b0;
            move_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.half_elevatorPositions = {pos[1], pos[0]};
  assign bus.floorArrived           = {arrived[1], arrived[0]};
  assign bus.moving                 = move_q;
`ifdef ELEVATOR_ESTOP_EN
  assign bus.doorsOpen = door_q | ({2{bus.estop}} & {~pos[1][0], ~pos[0][0]});
`else
  assign bus.doorsOpen = door_q;
`endif

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Self-checking bench for elevator_motion_controller (STEP_CYCLES=4,
// DOOR_CYCLES=6): directed scenarios plus a randomized run against an
// event/timer-based reference model of both cars.
module tb_elevator_motion_controller;
  localparam int STEP = 4;
  localparam int DOOR = 6;

  logic clk = 1'b0;
  logic rst;

  elevator_motion_controller_if bus();

  elevator_motion_controller #(
    .STEP_CYCLES(STEP),
    .DOOR_CYCLES(DOOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: mode 0 idle, 1 travelling, 2 doors open; tmr = cycles
  // left until the current step or door period ends.
  int         m_pos  [2];
  int         m_mode [2];
  int         m_tmr  [2];
  int         m_dir  [2];
  logic [11:0] m_arr;

  function automatic bit blk(int d, int p);
    return (d != 0) ? (p == 10) : (p == 0);
  endfunction

  function automatic void model_step();
    logic [11:0] fd;
    fd    = bus.FloorDestinations;
    m_arr = '0;
    if (rst) begin
      for (int e = 0; e < 2; e++) begin
        m_pos[e] = 0; m_mode[e] = 0; m_tmr[e] = 0; m_dir[e] = 0;
      end
      return;
    end
    if (bus.simState != 2'b01) return;
    for (int e = 0; e < 2; e++) begin
      logic [5:0] dst;
      int         din;
      dst = 6'(fd >> (6 * e));
      din = int'(bus.directions[e]);
      case (m_mode[e])
        0: begin
          if ((m_pos[e] % 2 == 0) && dst[m_pos[e] / 2]) begin
            m_mode[e] = 2; m_tmr[e] = DOOR;
            m_arr[6 * e + m_pos[e] / 2] = 1'b1;
          end else if (dst != 0 && !blk(din, m_pos[e])) begin
            m_mode[e] = 1; m_dir[e] = din; m_tmr[e] = STEP;
          end
        end
        1: begin
          m_tmr[e]--;
          if (m_tmr[e] == 0) begin
            m_pos[e] += (m_dir[e] != 0) ? 1 : -1;
            m_tmr[e] = STEP;
            if (m_pos[e] % 2 == 0) begin
              if (dst[m_pos[e] / 2]) begin
                m_mode[e] = 2; m_tmr[e] = DOOR;
                m_arr[6 * e + m_pos[e] / 2] = 1'b1;
              end else if (dst == 0) begin
                m_mode[e] = 0;
              end else begin
                m_dir[e] = din;
                if (blk(din, m_pos[e])) m_mode[e] = 0;
              end
            end
          end
        end
        default: begin
          m_tmr[e]--;
          if (m_tmr[e] == 0) m_mode[e] = 0;
        end
      endcase
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_cmp++; if (bus.half_elevatorPositions !== 8'h00) begin n_bad++; $display("FAIL reset_pos got %h want 00", bus.half_elevatorPositions); end
    n_cmp++; if (bus.floorArrived !== 12'h000) begin n_bad++; $display("FAIL reset_arr got %h want 000", bus.floorArrived); end
    n_cmp++; if (bus.doorsOpen !== 2'b00) begin n_bad++; $display("FAIL reset_door got %b want 00", bus.doorsOpen); end
    n_cmp++; if (bus.moving !== 2'b00) begin n_bad++; $display("FAIL reset_move got %b want 00", bus.moving); end
    rst = 1'b0; bus.FloorDestinations = 12'h040; tick();
    n_cmp++; if (bus.doorsOpen !== 2'b10) begin n_bad++; $display("FAIL right_door got %b want 10", bus.doorsOpen); end
    rst = 1'b1; bus.simState = 2'b00; tick();
    rst = 1'b0; bus.simState = 2'b01; bus.FloorDestinations = '0;
    n_cmp++; if (bus.doorsOpen !== 2'b00 || bus.floorArrived !== 12'h000) begin n_bad++; $display("FAIL reset_in_door got %b/%h want 00/000", bus.doorsOpen, bus.floorArrived); end
  endtask

  task automatic test_door_at_floor();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.FloorDestinations = 12'h001; tick();
    n_cmp++; if (bus.floorArrived !== 12'h001) begin n_bad++; $display("FAIL door_arr got %h want 001", bus.floorArrived); end
    n_cmp++; if (bus.doorsOpen !== 2'b01) begin n_bad++; $display("FAIL door_open got %b want 01", bus.doorsOpen); end
    bus.FloorDestinations = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++; if (bus.doorsOpen !== 2'b01 || bus.floorArrived !== 12'h000) begin n_bad++; $display("FAIL door_hold k=%0d got %b/%h want 01/000", k, bus.doorsOpen, bus.floorArrived); end
    end
    tick();
    n_cmp++; if (bus.doorsOpen !== 2'b00 || bus.half_elevatorPositions !== 8'h00) begin n_bad++; $display("FAIL door_close got %b/%h want 00/00", bus.doorsOpen, bus.half_elevatorPositions); end
  endtask

  task automatic test_move_up();
    logic [3:0] ep;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.FloorDestinations = 12'h004; bus.directions = 2'b01;
    for (int k = 1; k <= 17; k++) begin
      tick();
      ep = 4'((k - 1) / 4);
      n_cmp++; if (bus.half_elevatorPositions[3:0] !== ep) begin n_bad++; $display("FAIL up_pos k=%0d got %0d want %0d", k, bus.half_elevatorPositions[3:0], ep); end
      n_cmp++; if (bus.moving[0] !== (k < 17)) begin n_bad++; $display("FAIL up_move k=%0d got %b want %b", k, bus.moving[0], (k < 17)); end
      n_cmp++; if (bus.floorArrived !== ((k == 17) ? 12'h004 : 12'h000)) begin n_bad++; $display("FAIL up_arr k=%0d got %h", k, bus.floorArrived); end
    end
    bus.FloorDestinations = '0;
    repeat (DOOR) tick();
  endtask

  task automatic test_blocked();
    int c;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.FloorDestinations = 12'h020; bus.directions = 2'b01;
    c = 0;
    do begin tick(); c++; end while (bus.floorArrived[5] !== 1'b1 && c < 100);
    n_cmp++; if (bus.floorArrived[5] !== 1'b1 || bus.half_elevatorPositions[3:0] !== 4'd10) begin n_bad++; $display("FAIL top_reach got arr=%b pos=%0d want 1/10", bus.floorArrived[5], bus.half_elevatorPositions[3:0]); end
    bus.FloorDestinations = '0;
    repeat (DOOR) tick();
    bus.FloorDestinations = 12'h001; bus.directions = 2'b01;
    repeat (8) tick();
    n_cmp++; if (bus.moving[0] !== 1'b0 || bus.half_elevatorPositions[3:0] !== 4'd10) begin n_bad++; $display("FAIL blocked got mv=%b pos=%0d want 0/10", bus.moving[0], bus.half_elevatorPositions[3:0]); end
    bus.directions = 2'b00;
    c = 0;
    do begin tick(); c++; end while (bus.floorArrived[0] !== 1'b1 && c < 100);
    n_cmp++; if (bus.floorArrived[0] !== 1'b1 || bus.half_elevatorPositions[3:0] !== 4'd0) begin n_bad++; $display("FAIL descend got arr=%b pos=%0d want 1/0", bus.floorArrived[0], bus.half_elevatorPositions[3:0]); end
    n_cmp++; if (c != 41) begin n_bad++; $display("FAIL descend_time got %0d want 41", c); end
    bus.FloorDestinations = '0;
    repeat (DOOR) tick();
  endtask

  task automatic test_simultaneous();
    logic [3:0] p;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.FloorDestinations = 12'h082; bus.directions = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      p = 4'((k - 1) / 4);
      n_cmp++; if (bus.half_elevatorPositions !== {p, p}) begin n_bad++; $display("FAIL both_pos k=%0d got %h want %h", k, bus.half_elevatorPositions, {p, p}); end
      n_cmp++; if (bus.floorArrived !== ((k == 9) ? 12'h082 : 12'h000)) begin n_bad++; $display("FAIL both_arr k=%0d got %h", k, bus.floorArrived); end
    end
    bus.FloorDestinations = '0;
    repeat (DOOR) tick();
  endtask

  task automatic test_freeze_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.FloorDestinations = 12'h004; bus.directions = 2'b01;
    repeat (3) tick();
    bus.simState = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if (bus.half_elevatorPositions !== 8'h00 || bus.moving !== 2'b01) begin n_bad++; $display("FAIL frozen k=%0d got %h/%b want 00/01", k, bus.half_elevatorPositions, bus.moving); end
    end
    bus.simState = 2'b01; tick();
    n_cmp++; if (bus.half_elevatorPositions !== 8'h00) begin n_bad++; $display("FAIL resume1 got %h want 00", bus.half_elevatorPositions); end
    tick();
    n_cmp++; if (bus.half_elevatorPositions !== 8'h01) begin n_bad++; $display("FAIL resume2 got %h want 01", bus.half_elevatorPositions); end
    tick();
    rst = 1'b1; bus.simState = 2'b00; tick();
    rst = 1'b0; bus.simState = 2'b01; bus.FloorDestinations = '0;
    n_cmp++; if ({bus.half_elevatorPositions, bus.floorArrived, bus.doorsOpen, bus.moving} !== 24'h0) begin n_bad++; $display("FAIL mid_move_rst got %h/%h/%b/%b want all 0", bus.half_elevatorPositions, bus.floorArrived, bus.doorsOpen, bus.moving); end
    repeat (4) tick();
    n_cmp++; if (bus.half_elevatorPositions !== 8'h00 || bus.floorArrived !== 12'h000) begin n_bad++; $display("FAIL after_rst got %h/%h want 00/000", bus.half_elevatorPositions, bus.floorArrived); end
  endtask

  task automatic test_random();
    logic [7:0] ep;
    logic [1:0] ed, em;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) bus.FloorDestinations = 12'($urandom) & 12'($urandom) & 12'($urandom);
      if ($urandom_range(0, 7) == 0) bus.directions = 2'($urandom);
      bus.simState = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b01;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      ep = {4'(m_pos[1]), 4'(m_pos[0])};
      ed = {m_mode[1] == 2, m_mode[0] == 2};
      em = {m_mode[1] == 1, m_mode[0] == 1};
      n_cmp++; if (bus.half_elevatorPositions !== ep) begin n_bad++; $display("FAIL rnd_pos c=%0d got %h want %h", c, bus.half_elevatorPositions, ep); end
      n_cmp++; if (bus.floorArrived !== m_arr) begin n_bad++; $display("FAIL rnd_arr c=%0d got %h want %h", c, bus.floorArrived, m_arr); end
      n_cmp++; if (bus.doorsOpen !== ed) begin n_bad++; $display("FAIL rnd_door c=%0d got %b want %b", c, bus.doorsOpen, ed); end
      n_cmp++; if (bus.moving !== em) begin n_bad++; $display("FAIL rnd_move c=%0d got %b want %b", c, bus.moving, em); end
      n_cmp++; if (bus.half_elevatorPositions[3:0] > 4'd10 || bus.half_elevatorPositions[7:4] > 4'd10) begin n_bad++; $display("FAIL pos_bound c=%0d got %h want <=10 each", c, bus.half_elevatorPositions); end
    end
    rst = 1'b0; bus.simState = 2'b01;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.simState          = 2'b01;
    bus.directions        = 2'b00;
    bus.FloorDestinations = '0;
`ifdef ELEVATOR_ESTOP_EN
    bus.estop             = 1'b0;
`endif
    test_reset();
    test_door_at_floor();
    test_move_up();
    test_blocked();
    test_simultaneous();
    test_freeze_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
